// File: rtl/maxpool2_ctrl.sv
// -----------------------------------------------------------------------------
// maxpool2_ctrl
//
// Sequencer for a 2x2, stride-2, unsigned max-pool over a row-major feature
// map in local SRAM. Each window is fetched with four single-port reads,
// reduced by a 2x2 max unit, and one pooled pixel is written per window.
// Windows are visited in row-major (r, c) order.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                one-cycle launch pulse, sampled only in IDLE
//   in_width, in_height  input map size, latched on start
//   src_base, dst_base   input / output map base addresses, latched on start
//   rd_en, rd_addr       read request; rd_data returns one cycle later
//   rd_data              read data
//   wr_en, wr_addr,      write request, held until wr_ready is seen
//   wr_data
//   wr_ready             write accepted when wr_en && wr_ready
//   busy                 high while a job is in progress
//   done                 one-cycle completion pulse
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// RD0    | read pixel (0,0) of the current window
// RD1    | read pixel (0,1), capture (0,0)
// RD2    | read pixel (1,0), capture (0,1)
// RD3    | read pixel (1,1), capture (1,0)
// LAST   | capture (1,1)
// WR     | present pooled pixel, wait for wr_ready
// FIN    | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module maxpool2_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  in_width,
  input  logic [DIM_WIDTH-1:0]  in_height,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD0  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_RD3  = 4'd4,
    S_LAST = 4'd5,
    S_WR   = 4'd6,
    S_FIN  = 4'd7
  } state_t;

  state_t state;

  // Latched job geometry
  logic [DIM_WIDTH-1:0]  ow;
  logic [DIM_WIDTH-1:0]  oh;
  logic [ADDR_WIDTH-1:0] row_stride;

  // Window position
  logic [DIM_WIDTH-1:0]  row_cnt;
  logic [DIM_WIDTH-1:0]  col_cnt;
  logic [ADDR_WIDTH-1:0] row_base;   // address of input row 2r, column 0
  logic [ADDR_WIDTH-1:0] win_addr;   // address of pixel (0,0) of the window

  // Window registers, filled in read order (0,0) (0,1) (1,0) (1,1)
  logic [DATA_WIDTH-1:0] win0;
  logic [DATA_WIDTH-1:0] win1;
  logic [DATA_WIDTH-1:0] win2;
  logic [DATA_WIDTH-1:0] win3;

  logic [DIM_WIDTH-1:0]  cfg_ow;
  logic [DIM_WIDTH-1:0]  cfg_oh;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic                  cfg_empty;

  logic                  last_col;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] next_row_base;
  logic [ADDR_WIDTH-1:0] next_win_addr;

  assign cfg_ow     = in_width  >> 1;
  assign cfg_oh     = in_height >> 1;
  assign cfg_stride = ADDR_WIDTH'(in_width);
  assign cfg_empty  = (cfg_ow == '0) || (cfg_oh == '0);

  assign last_col = (col_cnt == ow - DIM_WIDTH'(1));
  assign last_row = (row_cnt == oh - DIM_WIDTH'(1));

  // A window row spans two input rows, so the next row of windows starts
  // two strides further on.
  assign next_row_base = row_base + (row_stride << 1);
  assign next_win_addr = last_col ? next_row_base : (win_addr + ADDR_WIDTH'(2));

  // 2x2 unsigned max unit. Fed only from the window registers, so the write
  // port never sees rd_data combinationally, and wr_data holds through a
  // stalled WR because the window registers do not change there.
  logic [DATA_WIDTH-1:0] max_top;
  logic [DATA_WIDTH-1:0] max_bot;

  assign max_top = (win0 >= win1) ? win0 : win1;
  assign max_bot = (win2 >= win3) ? win2 : win3;
  assign wr_data = (max_top >= max_bot) ? max_top : max_bot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ow         <= '0;
      oh         <= '0;
      row_stride <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      row_base   <= '0;
      win_addr   <= '0;
      win0       <= '0;
      win1       <= '0;
      win2       <= '0;
      win3       <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ow         <= cfg_ow;
            oh         <= cfg_oh;
            row_stride <= cfg_stride;
            row_cnt    <= '0;
            col_cnt    <= '0;
            row_base   <= src_base;
            win_addr   <= src_base;
            wr_addr    <= dst_base;
            if (cfg_empty) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state   <= S_RD0;
              rd_en   <= 1'b1;
              rd_addr <= src_base;
              busy    <= 1'b1;
            end
          end
        end

        S_RD0: begin
          state   <= S_RD1;
          rd_addr <= win_addr + ADDR_WIDTH'(1);
        end

        S_RD1: begin
          win0    <= rd_data;
          state   <= S_RD2;
          rd_addr <= win_addr + row_stride;
        end

        S_RD2: begin
          win1    <= rd_data;
          state   <= S_RD3;
          rd_addr <= win_addr + row_stride + ADDR_WIDTH'(1);
        end

        S_RD3: begin
          win2  <= rd_data;
          state <= S_LAST;
          rd_en <= 1'b0;
        end

        S_LAST: begin
          win3  <= rd_data;
          state <= S_WR;
          wr_en <= 1'b1;
        end

        S_WR: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_col && last_row) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_RD0;
              rd_en    <= 1'b1;
              rd_addr  <= next_win_addr;
              win_addr <= next_win_addr;
              // Output map is dense row-major, so the destination just steps.
              wr_addr  <= wr_addr + ADDR_WIDTH'(1);
              if (last_col) begin
                col_cnt  <= '0;
                row_cnt  <= row_cnt + DIM_WIDTH'(1);
                row_base <= next_row_base;
              end else begin
                col_cnt <= col_cnt + DIM_WIDTH'(1);
              end
            end
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          rd_en <= 1'b0;
          wr_en <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maxpool2_ctrl.md
# maxpool2_ctrl

Sequencer that runs a 2x2, stride-2 max-pool over a feature map held in the accelerator's local SRAM. It fetches each 2x2 window through a single-port read interface, reduces it with an internal 2x2 unsigned max unit, and writes one pooled pixel per window to a destination region. Software or the layer scheduler configures it, pulses `start`, and waits for `done`.

## Interface
- `DATA_WIDTH`, 8: pixel width, unsigned.
- `ADDR_WIDTH`, 16: SRAM word-address width.
- `DIM_WIDTH`, 8: width of the map dimension inputs.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle launch pulse. Sampled only in IDLE.
- `in_width` in DIM_WIDTH: input map columns. Latched on `start`.
- `in_height` in DIM_WIDTH: input map rows. Latched on `start`.
- `src_base` in ADDR_WIDTH: input map base address, row-major. Latched on `start`.
- `dst_base` in ADDR_WIDTH: output map base address. Latched on `start`.
- `rd_en` out 1: read request.
- `rd_addr` out ADDR_WIDTH: read address.
- `rd_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `rd_en`.
- `wr_en` out 1: write request. Held until accepted.
- `wr_addr` out ADDR_WIDTH: write address.
- `wr_data` out DATA_WIDTH: pooled pixel.
- `wr_ready` in 1: write accepted in any cycle where `wr_en && wr_ready`.
- `busy` out 1: high while a job is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Output dimensions: OW = in_width>>1, OH = in_height>>1. An odd trailing column or row is ignored.
- Windows are processed in row-major order of (r, c), with r in 0..OH-1 and c in 0..OW-1.
- Window pixel (i, j), with i, j in {0, 1}, is read from src_base + (2r+i)*in_width + 2c+j.
  - Read order: (0,0), (0,1), (1,0), (1,1).
- Each result is written to dst_base + r*OW + c.
- All address arithmetic is modulo 2^ADDR_WIDTH.
- Result = max of the 4 pixels, unsigned compare. Ties are irrelevant because all tied values are equal.
- FSM states:
  - IDLE
  - RD0, RD1, RD2, RD3: each issues one read.
  - LAST: captures the final pixel.
  - WR
  - FIN
- Transitions:
  - IDLE -> RD0 on `start` when OW != 0 and OH != 0.
  - IDLE -> FIN on `start` when OW = 0 or OH = 0.
  - RD0 -> RD1 -> RD2 -> RD3 -> LAST -> WR.
  - WR -> RD0 of the next window when `wr_ready` = 1 and windows remain.
  - WR -> FIN when `wr_ready` = 1 and the last window is accepted.
  - WR -> WR when `wr_ready` = 0.
  - FIN -> IDLE.
- Read capture:
  - In RD1, RD2, RD3 and LAST, `rd_data` is stored into window registers 0, 1, 2, 3 respectively.
  - `rd_en` is high only in RD0–RD3.
- Write outputs:
  - `wr_en` is high only in WR.
  - `wr_addr` and `wr_data` are stable throughout a stalled WR.
- `start` is ignored whenever the FSM is not in IDLE. Config inputs are ignored after latching.
- Reset, including mid-job:
  - FSM returns to IDLE and the window/row/col counters clear.
  - All outputs go to 0: `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`.
  - The partial job is abandoned; no further reads or writes are issued.
- Outputs are registered or decoded directly from state, with no combinational path from `rd_data` to the write port except via the window registers.

## Timing
- Cycle 0: IDLE, `start` = 1.
- Cycle 1: RD0, `rd_en` = 1.
- Per window, with no stall: 6 cycles (RD0..WR).
- `busy`:
  - rises in cycle 1;
  - stays high through the final accepted WR;
  - is low in FIN and IDLE.
- `done` is high only in FIN, i.e. the cycle after the last write is accepted, or cycle 1 for a zero-size job.
- Total latency, start to done, with `wr_ready` tied high: 6*OW*OH + 1 cycles.
- Each cycle of `wr_ready` = 0 in WR adds exactly 1 cycle.
- A new `start` is accepted in the cycle after FIN, in IDLE.

## Test plan
- 4x4 map, src_base=0x100, dst_base=0x200, pixels = 0..15, `wr_ready`=1.
  - Writes in order: 0x200←5, 0x201←7, 0x202←13, 0x203←15.
  - `done` pulses at cycle 25.
- 2x2 map with pixels {0xFF, 0x00, 0x80, 0x7F}.
  - Single write of 0xFF (checks unsigned compare).
  - Read addresses are base, base+1, base+2, base+3.
- 4x2 map with `wr_ready` held low for 3 cycles on the first write.
  - `wr_en`, `wr_addr` and `wr_data` stay stable for those cycles.
  - Exactly 2 writes total.
  - `done` arrives 3 cycles later than with no stall.
- 5x3 map:
  - OW=2, OH=1; reads touch rows 0–1 and columns 0–3 only.
  - 2 writes; column 4 and row 2 are never read.
- `in_width`=1 or `in_height`=0:
  - No `rd_en` and no `wr_en`.
  - `done` pulses in cycle 1.
- Reset and `start` handling on a 4x4 job:
  - `rst` asserted during the second window's RD2: all outputs are 0 the next cycle and no `done` is produced.
  - A fresh `start` afterwards completes normally with results identical to the first scenario.
  - `start` pulsed mid-job is ignored.
